// File: rtl/dpi_dispatch_pkg.sv
// Shared types and constants for the packet-to-character-stream dispatcher.
package dpi_dispatch_pkg;

    localparam int STREAM_W    = 6;
    localparam int NUM_STREAMS = 64;
    localparam int KEY_W       = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        LOAD,
        GAP,
        SERIAL,
        DRAIN,
        EOP
    } state_e;

    // Index of the final byte of a word; an nbytes field of 0 means a full word.
    function automatic logic [1:0] last_byte_idx(input logic is_eop, input logic [1:0] nbytes);
        return is_eop ? (nbytes - 2'd1) : 2'd3;
    endfunction

endpackage

// File: rtl/stream_table.sv
// Flow-key CAM: one-cycle lookup with allocate-on-miss at a wrapping pointer; result registered.
module stream_table
    import dpi_dispatch_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lookup_en,
    input  logic [KEY_W-1:0]    key,
    output logic [STREAM_W-1:0] sid,
    output logic                is_new
);

    logic [KEY_W-1:0]       keys_q [NUM_STREAMS];
    logic [KEY_W-1:0]       keys_d [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid_q, valid_d;
    logic [STREAM_W-1:0]    alloc_ptr_q, alloc_ptr_d;
    logic [STREAM_W-1:0]    sid_q, sid_d;
    logic                   is_new_q, is_new_d;
    logic                   hit;
    logic [STREAM_W-1:0]    hit_idx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (valid_q[i] && keys_q[i] == key) begin
                hit     = 1'b1;
                hit_idx = STREAM_W'(i);
            end
        end
    end

    always_comb begin
        keys_d      = keys_q;
        valid_d     = valid_q;
        alloc_ptr_d = alloc_ptr_q;
        sid_d       = sid_q;
        is_new_d    = is_new_q;
        if (lookup_en) begin
            if (hit) begin
                sid_d    = hit_idx;
                is_new_d = 1'b0;
            end else begin
                // Miss overwrites whatever occupies the slot; the pointer wraps naturally at 64.
                keys_d[alloc_ptr_q]  = key;
                valid_d[alloc_ptr_q] = 1'b1;
                sid_d                = alloc_ptr_q;
                is_new_d             = 1'b1;
                alloc_ptr_d          = alloc_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= '0;
            alloc_ptr_q <= '0;
            sid_q       <= '0;
            is_new_q    <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alloc_ptr_q <= alloc_ptr_d;
            sid_q       <= sid_d;
            is_new_q    <= is_new_d;
        end
    end

    always_ff @(posedge clk) begin
        keys_q <= keys_d;
    end

    assign sid    = sid_q;
    assign is_new = is_new_q;

endmodule

// File: rtl/pkt_stream_dispatch.sv
// Serializes 32-bit packet words into a per-flow byte stream for regex wrappers.
// Optional counters stat_pkts/stat_new_streams are built when DISPATCH_STATS_EN is defined.
module pkt_stream_dispatch
    import dpi_dispatch_pkg::*;
#(
    parameter int NUM_RX    = 4,
    parameter int DRAIN_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         in_data,
    input  logic                in_vld,
    input  logic                in_sop,
    input  logic                in_eop,
    input  logic [1:0]          in_nbytes,
    input  logic [31:0]         in_flow_key,
    output logic                in_rdy,
    input  logic [NUM_RX-1:0]   cfg_en_mask,
    output logic                load_state,
    output logic                new_stream_id,
    output logic                char_in_vld,
    output logic                eop,
    output logic [STREAM_W-1:0] stream_id,
    output logic [7:0]          char_in,
    output logic [NUM_RX-1:0]   enable,
    output logic                err_sticky,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]         stat_pkts,
    output logic [31:0]         stat_new_streams,
`endif
    output state_e              dbg_state
);

    localparam logic [7:0] DRAIN_LAST = 8'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    // Input handshake: a word transfers on a clk edge where in_vld && in_rdy.
    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         nbytes_q, nbytes_d;
    logic               last_q, last_d;
    logic               have_q, have_d;
    logic [1:0]         idx_q, idx_d;
    logic [NUM_RX-1:0]  en_q, en_d;
    logic               err_q, err_d;
    logic [7:0]         drain_cnt_q, drain_cnt_d;
    logic               rdy_c, take_word;

    stream_table u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup_en (state_q == LOOKUP),
        .key       (key_q),
        .sid       (stream_id),
        .is_new    (new_stream_id)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        word_d      = word_q;
        nbytes_d    = nbytes_q;
        last_d      = last_q;
        have_d      = have_q;
        idx_d       = idx_q;
        en_d        = en_q;
        err_d       = err_q;
        drain_cnt_d = drain_cnt_q;
        rdy_c       = 1'b0;
        take_word   = 1'b0;
        load_state  = 1'b0;
        char_in_vld = 1'b0;
        char_in     = 8'h00;
        eop         = 1'b0;
        case (state_q)
            IDLE: begin
                rdy_c = 1'b1;
                if (in_vld) begin
                    if (in_sop) begin
                        key_d    = in_flow_key;
                        word_d   = in_data;
                        nbytes_d = in_nbytes;
                        last_d   = in_eop;
                        en_d     = cfg_en_mask;
                        have_d   = 1'b1;
                        idx_d    = 2'd0;
                        state_d  = LOOKUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOOKUP: state_d = LOAD;
            LOAD: begin
                load_state = 1'b1;
                state_d    = GAP;
            end
            GAP: state_d = SERIAL;
            SERIAL: begin
                if (have_q) begin
                    char_in_vld = 1'b1;
                    char_in     = word_q[{idx_q, 3'b000} +: 8];
                    if (idx_q == last_byte_idx(last_q, nbytes_q)) begin
                        have_d = 1'b0;
                        if (last_q) begin
                            drain_cnt_d = 8'd0;
                            state_d     = (DRAIN_CYC == 0) ? EOP : DRAIN;
                        end else begin
                            rdy_c     = 1'b1;
                            take_word = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    rdy_c     = 1'b1;
                    take_word = 1'b1;
                end
                // A stray sop mid-packet is flagged but its word is still streamed as data.
                if (take_word && in_vld) begin
                    word_d   = in_data;
                    nbytes_d = in_nbytes;
                    last_d   = in_eop;
                    have_d   = 1'b1;
                    idx_d    = 2'd0;
                    if (in_sop) err_d = 1'b1;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 8'd1;
                if (drain_cnt_q == DRAIN_LAST) state_d = EOP;
            end
            EOP: begin
                eop     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= '0;
            word_q      <= '0;
            nbytes_q    <= '0;
            last_q      <= 1'b0;
            have_q      <= 1'b0;
            idx_q       <= '0;
            en_q        <= '0;
            err_q       <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            word_q      <= word_d;
            nbytes_q    <= nbytes_d;
            last_q      <= last_d;
            have_q      <= have_d;
            idx_q       <= idx_d;
            en_q        <= en_d;
            err_q       <= err_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_pkts_q, stat_pkts_d;
    logic [31:0] stat_new_q, stat_new_d;

    always_comb begin
        stat_pkts_d = stat_pkts_q;
        stat_new_d  = stat_new_q;
        if (state_q == EOP) stat_pkts_d = stat_pkts_q + 32'd1;
        if (state_q == LOAD && new_stream_id) stat_new_d = stat_new_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pkts_q <= '0;
            stat_new_q  <= '0;
        end else begin
            stat_pkts_q <= stat_pkts_d;
            stat_new_q  <= stat_new_d;
        end
    end

    assign stat_pkts        = stat_pkts_q;
    assign stat_new_streams = stat_new_q;
`endif

    // Ready is held low while reset is asserted, even though the state is already IDLE.
    assign in_rdy     = rdy_c & rst_n;
    assign enable     = en_q;
    assign err_sticky = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pkt_stream_dispatch.sv
// Self-checking bench for pkt_stream_dispatch: directed table, random packets vs. a flow-table model.
module tb_pkt_stream_dispatch;
    import dpi_dispatch_pkg::*;

    localparam int NUM_RX    = 4;
    localparam int DRAIN_CYC = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       in_data = '0;
    logic              in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [1:0]        in_nbytes = '0;
    logic [31:0]       in_flow_key = '0;
    logic              in_rdy;
    logic [NUM_RX-1:0] cfg_en_mask = '0;
    logic              load_state, new_stream_id, char_in_vld, eop;
    logic [5:0]        stream_id;
    logic [7:0]        char_in;
    logic [NUM_RX-1:0] enable;
    logic              err_sticky;
    state_e            dbg_state;
`ifdef DISPATCH_STATS_EN
    logic [31:0]       stat_pkts, stat_new_streams;
`endif

    pkt_stream_dispatch #(.NUM_RX(NUM_RX), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_sop(in_sop),
        .in_eop(in_eop), .in_nbytes(in_nbytes), .in_flow_key(in_flow_key), .in_rdy(in_rdy),
        .cfg_en_mask(cfg_en_mask), .load_state(load_state), .new_stream_id(new_stream_id),
        .char_in_vld(char_in_vld), .eop(eop), .stream_id(stream_id), .char_in(char_in),
        .enable(enable), .err_sticky(err_sticky),
`ifdef DISPATCH_STATS_EN
        .stat_pkts(stat_pkts), .stat_new_streams(stat_new_streams),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- flow table reference model ----------------
    logic [31:0] m_key[64];
    bit          m_vld[64];
    int          m_ptr;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] key, output int sid, output int is_new);
        for (int i = 0; i < 64; i++) begin
            if (m_vld[i] && m_key[i] == key) begin
                sid = i;
                is_new = 0;
                return;
            end
        end
        m_key[m_ptr] = key;
        m_vld[m_ptr] = 1'b1;
        sid    = m_ptr;
        is_new = 1;
        m_ptr  = (m_ptr + 1) % 64;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset(input bit check_outputs);
        rst_n  = 1'b0;
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        repeat (2) @(negedge clk);
        if (check_outputs) begin
            check("rst_in_rdy", 32'(in_rdy), 0);
            check("rst_load_state", 32'(load_state), 0);
            check("rst_char_in_vld", 32'(char_in_vld), 0);
            check("rst_eop", 32'(eop), 0);
            check("rst_new_stream_id", 32'(new_stream_id), 0);
            check("rst_stream_id", 32'(stream_id), 0);
            check("rst_char_in", 32'(char_in), 0);
            check("rst_enable", 32'(enable), 0);
            check("rst_err_sticky", 32'(err_sticky), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (check_outputs) check("idle_in_rdy", 32'(in_rdy), 1);
        model_reset();
    endtask

    // Sends one packet and checks its byte stream, timing and flow slot. Called at a negedge.
    task automatic run_pkt(input logic [31:0] key, input int nbytes, input int gap,
                           input logic [7:0] seed, input logic [3:0] mask, input bit mid_sop,
                           output int got_sid, output int got_new);
        int nwords, m_sid, m_new;
        int t_load, t_first, t_last, t_eop, n_load, n_eop;
        logic [5:0] sid_eop;
        logic       new_eop;
        logic [3:0] en_l;
        logic [7:0] pb[$];
        nwords = (nbytes + 3) / 4;
        pb.delete();
        for (int i = 0; i < nbytes; i++) pb.push_back(8'(seed + 8'(i * 17)));
        exp_q = pb;
        got_q.delete();
        model_lookup(key, m_sid, m_new);
        t_load = -1; t_first = -1; t_last = -1; t_eop = -1; n_load = 0; n_eop = 0;
        got_sid = -1; got_new = -1; sid_eop = '0; new_eop = 1'b0; en_l = '0;
        fork
            begin : drive
                for (int w = 0; w < nwords; w++) begin
                    int left, budget;
                    bit acc;
                    logic [31:0] wd;
                    left = (w == 0) ? 0 : gap;
                    in_vld = 1'b0;
                    budget = 0;
                    while (left > 0 && budget < 100) begin
                        if (in_rdy) left--;
                        budget++;
                        @(negedge clk);
                    end
                    wd = '0;
                    for (int j = 0; j < 4; j++)
                        if (w * 4 + j < nbytes) wd[j*8 +: 8] = pb[w * 4 + j];
                    in_data     = wd;
                    in_flow_key = key;
                    cfg_en_mask = mask;
                    in_sop      = (w == 0) || (mid_sop && w == 1);
                    in_eop      = (w == nwords - 1);
                    in_nbytes   = (w == nwords - 1) ? 2'(nbytes % 4) : 2'd0;
                    in_vld      = 1'b1;
                    acc         = 1'b0;
                    budget      = 0;
                    while (!acc && budget < 100) begin
                        acc = in_rdy;
                        budget++;
                        @(negedge clk);
                    end
                    if (!acc) check("drv_accept_timeout", 0, 1);
                end
                in_vld = 1'b0;
                in_sop = 1'b0;
                in_eop = 1'b0;
            end
            begin : monitor
                for (int k = 0; k < 400 && t_eop < 0; k++) begin
                    @(negedge clk);
                    if (load_state) begin
                        n_load++;
                        t_load  = cyc;
                        got_sid = int'(stream_id);
                        got_new = int'(new_stream_id);
                        en_l    = enable;
                    end
                    if (char_in_vld) begin
                        got_q.push_back(char_in);
                        if (t_first < 0) t_first = cyc;
                        t_last = cyc;
                    end
                    if (eop) begin
                        n_eop++;
                        t_eop   = cyc;
                        sid_eop = stream_id;
                        new_eop = new_stream_id;
                    end
                end
            end
        join
        check("eop_seen", 32'(n_eop), 1);
        check("load_count", 32'(n_load), 1);
        check("sid_model", 32'(got_sid), 32'(m_sid));
        check("new_model", 32'(got_new), 32'(m_new));
        check("sid_stable", 32'(sid_eop), 32'(got_sid));
        check("new_stable", 32'(new_eop), 32'(got_new));
        check("enable_latched", 32'(en_l), 32'(mask));
        check("load_to_char", 32'(t_first - t_load), 2);
        check("char_to_eop", 32'(t_eop - t_last), 32'(DRAIN_CYC + 1));
        check("bubbles", 32'((t_last - t_first + 1) - nbytes), 32'(gap * (nwords - 1)));
        check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("byte_value", 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] key;
        int          nbytes;
        int          gap;
        logic [7:0]  seed;
        logic [3:0]  mask;
        int          exp_sid;
        int          exp_new;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int sid, isn;
        logic [31:0] pool[6];

        vecs[0] = '{32'hA5A5_0001, 5,  0, 8'h11, 4'b1010, 0, 1};
        vecs[1] = '{32'hA5A5_0001, 3,  0, 8'h40, 4'b0101, 0, 0};
        vecs[2] = '{32'hA5A5_0002, 1,  0, 8'h99, 4'b1111, 1, 1};
        vecs[3] = '{32'hA5A5_0002, 10, 3, 8'h01, 4'b0011, 1, 0};
        vecs[4] = '{32'hA5A5_0001, 4,  1, 8'hC0, 4'b1000, 0, 0};

        do_reset(1'b1);

        for (int v = 0; v < 5; v++) begin
            run_pkt(vecs[v].key, vecs[v].nbytes, vecs[v].gap, vecs[v].seed, vecs[v].mask,
                    1'b0, sid, isn);
            check("vec_sid", 32'(sid), 32'(vecs[v].exp_sid));
            check("vec_new", 32'(isn), 32'(vecs[v].exp_new));
        end
        check("no_err_after_clean", 32'(err_sticky), 0);

        // Random packets over a small key pool so hits and misses both occur.
        for (int i = 0; i < 6; i++) pool[i] = $urandom;
        for (int p = 0; p < 16; p++) begin
            run_pkt(pool[$urandom_range(0, 5)], $urandom_range(1, 12), $urandom_range(0, 2),
                    8'($urandom), 4'($urandom), 1'b0, sid, isn);
        end
        check("no_err_after_rand", 32'(err_sticky), 0);

        // Stray sop inside a packet: flagged, bytes still streamed.
        do_reset(1'b0);
        run_pkt(32'h0BAD_5050, 7, 0, 8'h21, 4'b0110, 1'b1, sid, isn);
        check("mid_sop_err", 32'(err_sticky), 1);

        // Word without sop in IDLE is dropped.
        do_reset(1'b0);
        check("err_cleared", 32'(err_sticky), 0);
        begin
            int loads = 0;
            in_data = 32'hDEAD_BEEF;
            in_vld  = 1'b1;
            in_sop  = 1'b0;
            in_eop  = 1'b1;
            @(negedge clk);
            in_vld = 1'b0;
            in_eop = 1'b0;
            for (int k = 0; k < 6; k++) begin
                if (load_state) loads++;
                @(negedge clk);
            end
            check("nosop_no_load", 32'(loads), 0);
            check("nosop_err", 32'(err_sticky), 1);
        end

        // Reset in the middle of serialization abandons the packet.
        do_reset(1'b0);
        begin
            int waited = 0, eops = 0;
            in_data     = 32'h4433_2211;
            in_flow_key = 32'h1234_5678;
            cfg_en_mask = 4'hF;
            in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_nbytes = 2'd0;
            @(negedge clk);
            in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
            while (!char_in_vld && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            check("serial_reached", 32'(char_in_vld), 1);
            do_reset(1'b1);
            for (int k = 0; k < 12; k++) begin
                if (eop) eops++;
                @(negedge clk);
            end
            check("abandon_no_eop", 32'(eops), 0);
        end

        // 65 distinct keys: slot 0 is evicted and reused.
        do_reset(1'b0);
        for (int i = 0; i < 65; i++) begin
            run_pkt(32'h7000_0000 + 32'(i), 1, 0, 8'(i), 4'h1, 1'b0, sid, isn);
            if (i == 64) begin
                check("wrap65_sid", 32'(sid), 0);
                check("wrap65_new", 32'(isn), 1);
            end
        end
        run_pkt(32'h7000_0000, 2, 0, 8'h5A, 4'h2, 1'b0, sid, isn);
        check("evicted_sid", 32'(sid), 1);
        check("evicted_new", 32'(isn), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
